// File: rtl/led_pattern_gen.sv
// LED pattern engine: SHIFT / FLASH / PINGPONG animations, four speeds, RGB routing.
// Define LED_PWM_DIM_EN to add btn2-controlled PWM dimming of the colour outputs.
module led_pattern_gen #(
  parameter int NB_LED     = 4,
  parameter int NB_CNT     = 16,
  parameter int NB_BUTTONS = 4,
  parameter int NB_SW      = 4,
  parameter int LIMIT_0    = 15,
  parameter int LIMIT_1    = 31,
  parameter int LIMIT_2    = 63,
  parameter int LIMIT_3    = 127
) (
  input  logic                  clock,
  input  logic                  i_reset,
  input  logic [NB_SW-1:0]      i_sw,
  input  logic [NB_BUTTONS-1:0] i_btn,
  output logic [NB_LED-1:0]     o_led,
  output logic [NB_LED-1:0]     o_led_r,
  output logic [NB_LED-1:0]     o_led_g,
  output logic [NB_LED-1:0]     o_led_b,
  output logic                  o_tick
);

  typedef enum logic [1:0] {M_SHIFT, M_FLASH, M_PINGPONG} mode_e;
  typedef enum logic [1:0] {C_RED, C_GREEN, C_BLUE} colour_e;

  logic [3:0]        sync1_q, sync2_q, hist_q, btn_edge;
  mode_e             mode_q, mode_d, mode_nxt, load_mode;
  colour_e           colour_q, colour_d;
  logic [NB_LED-1:0] pattern_q, pattern_d;
  logic              dir_up_q, dir_up_d;
  logic [NB_CNT-1:0] cnt_q, cnt_d, limit;
  logic              tick_q, tick_d;
  logic              pwm_on;
  logic              unused_in;

  assign unused_in = ^{i_sw, i_btn, btn_edge};

  // Two-flop synchroniser plus history flop gives a single-cycle rising-edge pulse.
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      hist_q  <= '0;
    end else begin
      sync1_q <= i_btn[3:0];
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end
  assign btn_edge = sync2_q & ~hist_q;

  always_comb begin
    case (i_sw[2:1])
      2'd0:    limit = NB_CNT'(LIMIT_0);
      2'd1:    limit = NB_CNT'(LIMIT_1);
      2'd2:    limit = NB_CNT'(LIMIT_2);
      default: limit = NB_CNT'(LIMIT_3);
    endcase
  end

  always_comb begin
    case (mode_q)
      M_SHIFT: mode_nxt = M_FLASH;
      M_FLASH: mode_nxt = M_PINGPONG;
      default: mode_nxt = M_SHIFT;
    endcase
  end

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      mode_q    <= M_SHIFT;
      colour_q  <= C_RED;
      pattern_q <= NB_LED'(1);
      dir_up_q  <= 1'b1;
      cnt_q     <= '0;
      tick_q    <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      colour_q  <= colour_d;
      pattern_q <= pattern_d;
      dir_up_q  <= dir_up_d;
      cnt_q     <= cnt_d;
      tick_q    <= tick_d;
    end
  end

  always_comb begin
    mode_d    = mode_q;
    colour_d  = colour_q;
    pattern_d = pattern_q;
    dir_up_d  = dir_up_q;
    cnt_d     = cnt_q;
    tick_d    = 1'b0;
    load_mode = btn_edge[0] ? mode_nxt : mode_q;

    // >= rather than == so a downshift in speed never has to wrap the counter.
    if (i_sw[0]) begin
      if (cnt_q >= limit) begin
        cnt_d  = '0;
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + NB_CNT'(1);
      end
    end

    if (tick_d) begin
      case (mode_q)
        M_SHIFT:
          pattern_d = i_sw[3] ? {pattern_q[0], pattern_q[NB_LED-1:1]}
                              : {pattern_q[NB_LED-2:0], pattern_q[NB_LED-1]};
        M_FLASH: pattern_d = ~pattern_q;
        M_PINGPONG: begin
          if (dir_up_q) begin
            if (pattern_q[NB_LED-1]) begin
              dir_up_d  = 1'b0;
              pattern_d = pattern_q >> 1;
            end else begin
              pattern_d = pattern_q << 1;
            end
          end else begin
            if (pattern_q[0]) begin
              dir_up_d  = 1'b1;
              pattern_d = pattern_q << 1;
            end else begin
              pattern_d = pattern_q >> 1;
            end
          end
        end
        default: pattern_d = pattern_q;
      endcase
    end

    // Mode change or restart reloads the pattern and swallows any coincident tick.
    if (btn_edge[0] || btn_edge[3]) begin
      mode_d    = load_mode;
      pattern_d = (load_mode == M_FLASH) ? '0 : NB_LED'(1);
      dir_up_d  = 1'b1;
      cnt_d     = '0;
      tick_d    = 1'b0;
    end

    if (btn_edge[1]) begin
      case (colour_q)
        C_RED:   colour_d = C_GREEN;
        C_GREEN: colour_d = C_BLUE;
        default: colour_d = C_RED;
      endcase
    end
  end

`ifdef LED_PWM_DIM_EN
  // duty_q: 0 = 100%, 1 = 50%, 2 = 25%.
  logic [1:0] pwm_cnt_q, pwm_cnt_d, duty_q, duty_d;

  always_comb begin
    pwm_cnt_d = pwm_cnt_q + 2'd1;
    duty_d    = duty_q;
    if (btn_edge[2]) duty_d = (duty_q == 2'd2) ? 2'd0 : duty_q + 2'd1;
  end

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      pwm_cnt_q <= '0;
      duty_q    <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
      duty_q    <= duty_d;
    end
  end

  assign pwm_on = (duty_q == 2'd0) ||
                  ((duty_q == 2'd1) && !pwm_cnt_q[0]) ||
                  ((duty_q == 2'd2) && (pwm_cnt_q == 2'd0));
`else
  assign pwm_on = 1'b1;
`endif

  assign o_led   = pattern_q;
  assign o_led_r = (colour_q == C_RED   && pwm_on) ? pattern_q : '0;
  assign o_led_g = (colour_q == C_GREEN && pwm_on) ? pattern_q : '0;
  assign o_led_b = (colour_q == C_BLUE  && pwm_on) ? pattern_q : '0;
  assign o_tick  = tick_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Bench for led_pattern_gen: randomized speeds/directions against a tick-count pattern model.
module tb_led_pattern_gen;
  localparam int N = 4;

  logic         clock = 1'b0;
  logic         i_reset;
  logic [3:0]   i_sw, i_btn;
  logic [N-1:0] o_led, o_led_r, o_led_g, o_led_b;
  logic         o_tick;
  logic [4*N:0] obs;
  int n_chk = 0, n_pass = 0;
  int cur_mode = 0, cur_col = 0;

  led_pattern_gen dut (
    .clock(clock), .i_reset(i_reset), .i_sw(i_sw), .i_btn(i_btn),
    .o_led(o_led), .o_led_r(o_led_r), .o_led_g(o_led_g), .o_led_b(o_led_b),
    .o_tick(o_tick)
  );

  always #5 clock = ~clock;
  assign obs = {o_tick, o_led, o_led_r, o_led_g, o_led_b};

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Held for three edges: the resulting state change is visible on return.
  task automatic press(input logic [3:0] m);
    i_btn = m;
    step(3);
    i_btn = '0;
  endtask

  function automatic int period(input int spd);
    case (spd)
      0: return 16;
      1: return 32;
      2: return 64;
      default: return 128;
    endcase
  endfunction

  // Pattern after k ticks since a reload, in mode 0/1/2 (SHIFT/FLASH/PINGPONG).
  function automatic logic [N-1:0] exp_pat(input int mode, input int k, input bit right);
    int pos, p;
    logic [N-1:0] v;
    pos = 0;
    case (mode)
      0: pos = right ? (N - (k % N)) % N : k % N;
      1: return (k % 2 == 1) ? {N{1'b1}} : {N{1'b0}};
      default: begin
        p   = k % (2*N - 2);
        pos = (p < N) ? p : 2*N - 2 - p;
      end
    endcase
    v = '0;
    v[pos] = 1'b1;
    return v;
  endfunction

  function automatic logic [4*N:0] expv(input logic t, input logic [N-1:0] p);
    return {t, p, (cur_col == 0) ? p : {N{1'b0}}, (cur_col == 1) ? p : {N{1'b0}},
            (cur_col == 2) ? p : {N{1'b0}}};
  endfunction

  task automatic test_reset;
    logic [4*N:0] e;
    i_reset = 1'b0; i_sw = '0; i_btn = '0;
    e = {1'b0, 4'b0001, 4'b0001, 4'b0000, 4'b0000};
    for (int i = 0; i < 10; i++) begin
      step(1);
      n_chk++;
      if (obs !== e) $display("FAIL reset_hold cyc=%0d got=%b exp=%b", i, obs, e);
      else n_pass++;
    end
    i_reset = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step(1);
      n_chk++;
      if (obs !== e) $display("FAIL frozen_after_reset cyc=%0d got=%b exp=%b", i, obs, e);
      else n_pass++;
    end
  endtask

  task automatic test_shift;
    int spd, right, nt, p;
    logic [4*N:0] e;
    for (int it = 0; it < 3; it++) begin
      spd = $urandom_range(0, 3); right = $urandom_range(0, 1); nt = $urandom_range(3, 6);
      p = period(spd);
      i_sw = {right[0], spd[1:0], 1'b1};
      press(4'b1000);
      e = expv(1'b0, exp_pat(0, 0, right[0]));
      n_chk++;
      if (obs[4*N-1:0] !== e[4*N-1:0]) $display("FAIL shift_restart got=%b exp=%b", obs, e);
      else n_pass++;
      for (int c = 1; c <= p*nt; c++) begin
        step(1);
        e = expv(c % p == 0, exp_pat(0, c / p, right[0]));
        n_chk++;
        if (obs !== e) $display("FAIL shift spd=%0d r=%0d c=%0d got=%b exp=%b", spd, right, c, obs, e);
        else n_pass++;
      end
    end
  endtask

  task automatic test_downshift;
    logic [4*N:0] e;
    i_sw = 4'b0111;
    press(4'b1000);
    for (int c = 1; c <= 100; c++) begin
      step(1);
      e = expv(1'b0, exp_pat(0, 0, 1'b0));
      n_chk++;
      if (obs !== e) $display("FAIL slow_count c=%0d got=%b exp=%b", c, obs, e);
      else n_pass++;
    end
    i_sw = 4'b0001;
    step(1);
    e = expv(1'b1, exp_pat(0, 1, 1'b0));
    n_chk++;
    if (obs !== e) $display("FAIL downshift_tick got=%b exp=%b", obs, e);
    else n_pass++;
    for (int c = 1; c <= 48; c++) begin
      step(1);
      e = expv(c % 16 == 0, exp_pat(0, 1 + c / 16, 1'b0));
      n_chk++;
      if (obs !== e) $display("FAIL after_downshift c=%0d got=%b exp=%b", c, obs, e);
      else n_pass++;
    end
  endtask

  task automatic test_modes;
    logic [4*N:0] e;
    i_sw = 4'b0001;
    press(4'b0001);
    cur_mode = 1;
    e = expv(1'b0, exp_pat(1, 0, 1'b0));
    n_chk++;
    if (obs !== e) $display("FAIL enter_flash got=%b exp=%b", obs, e);
    else n_pass++;
    for (int c = 1; c <= 48; c++) begin
      step(1);
      e = expv(c % 16 == 0, exp_pat(1, c / 16, 1'b0));
      n_chk++;
      if (obs !== e) $display("FAIL flash c=%0d got=%b exp=%b", c, obs, e);
      else n_pass++;
    end
    press(4'b0001);
    cur_mode = 2;
    e = expv(1'b0, exp_pat(2, 0, 1'b0));
    n_chk++;
    if (obs !== e) $display("FAIL enter_pingpong got=%b exp=%b", obs, e);
    else n_pass++;
    for (int c = 1; c <= 192; c++) begin
      if (c == 129) i_sw = 4'b1001;
      step(1);
      e = expv(c % 16 == 0, exp_pat(2, c / 16, 1'b0));
      n_chk++;
      if (obs !== e) $display("FAIL pingpong c=%0d got=%b exp=%b", c, obs, e);
      else n_pass++;
    end
  endtask

  task automatic test_colour;
    logic [4*N:0] e;
    i_sw = 4'b0000;
    press(4'b1000);
    step(3);
    press(4'b0010);
    cur_col = 1;
    e = expv(1'b0, exp_pat(cur_mode, 0, 1'b0));
    n_chk++;
    if (obs !== e) $display("FAIL colour_green got=%b exp=%b", obs, e);
    else n_pass++;
    step(3);
    i_btn = 4'b0010;
    for (int i = 1; i <= 20; i++) begin
      step(1);
      if (i == 3) cur_col = 2;
      e = expv(1'b0, exp_pat(cur_mode, 0, 1'b0));
      n_chk++;
      if (obs !== e) $display("FAIL colour_held i=%0d got=%b exp=%b", i, obs, e);
      else n_pass++;
    end
    i_btn = '0;
    step(3);
  endtask

  task automatic test_simultaneous;
    logic [4*N:0] e;
    i_sw = 4'b0000;
    press(4'b0011);
    cur_mode = (cur_mode + 1) % 3;
    cur_col  = (cur_col + 1) % 3;
    e = expv(1'b0, exp_pat(cur_mode, 0, 1'b0));
    n_chk++;
    if (obs !== e) $display("FAIL mode_and_colour got=%b exp=%b", obs, e);
    else n_pass++;
    step(3);
    i_sw = 4'b0001;
    press(4'b1000);
    for (int c = 1; c <= 13; c++) begin
      step(1);
      e = expv(1'b0, exp_pat(cur_mode, 0, 1'b0));
      n_chk++;
      if (obs !== e) $display("FAIL pre_coincide c=%0d got=%b exp=%b", c, obs, e);
      else n_pass++;
    end
    // The btn0 edge lands on the same edge the counter reaches its limit.
    press(4'b0001);
    cur_mode = (cur_mode + 1) % 3;
    e = expv(1'b0, exp_pat(cur_mode, 0, 1'b0));
    n_chk++;
    if (obs !== e) $display("FAIL tick_suppressed got=%b exp=%b", obs, e);
    else n_pass++;
    for (int c = 1; c <= 32; c++) begin
      step(1);
      e = expv(c % 16 == 0, exp_pat(cur_mode, c / 16, 1'b0));
      n_chk++;
      if (obs !== e) $display("FAIL post_coincide c=%0d got=%b exp=%b", c, obs, e);
      else n_pass++;
    end
  endtask

  task automatic test_pwm;
    int hi;
    logic [N-1:0] p;
    i_sw = 4'b0000;
    step(3);
    if (cur_mode == 1) begin
      press(4'b0001);
      cur_mode = 2;
      step(3);
    end
    while (cur_col != 0) begin
      press(4'b0010);
      cur_col = (cur_col + 1) % 3;
      step(3);
    end
    press(4'b1000);
    step(3);
    press(4'b0100);
    step(3);
    press(4'b0100);
    step(3);
    p = exp_pat(cur_mode, 0, 1'b0);
    hi = 0;
    for (int i = 0; i < 16; i++) begin
      step(1);
      if (o_led_r !== '0) hi++;
      n_chk++;
      if (o_led !== p || (o_led_r !== p && o_led_r !== '0))
        $display("FAIL pwm_leds i=%0d led=%b r=%b exp_led=%b", i, o_led, o_led_r, p);
      else n_pass++;
    end
    n_chk++;
`ifdef LED_PWM_DIM_EN
    if (hi !== 4) $display("FAIL pwm_duty got=%0d exp=4", hi);
    else n_pass++;
`else
    if (hi !== 16) $display("FAIL pwm_duty got=%0d exp=16", hi);
    else n_pass++;
`endif
  endtask

  task automatic test_midop_reset;
    logic [4*N:0] e;
    i_sw = 4'b0001;
    press(4'b0001);
    step(40);
    @(posedge clock);
    #3 i_reset = 1'b0;
    #1;
    cur_mode = 0; cur_col = 0;
    e = {1'b0, 4'b0001, 4'b0001, 4'b0000, 4'b0000};
    n_chk++;
    if (obs !== e) $display("FAIL async_reset got=%b exp=%b", obs, e);
    else n_pass++;
    step(3);
    i_sw = 4'b0000;
    i_reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1);
      n_chk++;
      if (obs !== e) $display("FAIL after_async_reset i=%0d got=%b exp=%b", i, obs, e);
      else n_pass++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_shift();
    test_downshift();
    test_modes();
    test_colour();
    test_simultaneous();
    test_pwm();
    test_midop_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
